alu_rs: RTL and testbench
=========================

# alu_rs

Reservation station directly upstream of the ALU in the out-of-order core. It accepts decoded integer ops from the issue stage and holds them until both operands are known, capturing missing operands from the common data bus (CDB). It then dispatches one ready op per cycle to the ALU's `op` / `value_1` / `value_2` / `des_input` inputs. Tag 0 is reserved as "no destination": it is what the ALU sees on idle cycles.

## Interface
- ENTRIES, 4, number of station slots (2..8)
- TAG_W, 3, ROB tag width; tag 0 reserved, valid tags 1..2^TAG_W-1
- clk  in  1  system clock, all state on posedge
- rst  in  1  asynchronous, active-high reset
- issue_valid  in  1  new op presented this cycle
- issue_op  in  4  ALU opcode (ADD=0 … GEU=13), passed through unchanged
- issue_v1, issue_v2  in  32 each  operand values; meaningful only when the matching wait flag is 0
- issue_w1, issue_w2  in  1 each  operand still pending on a ROB tag
- issue_q1, issue_q2  in  TAG_W each  producing ROB tag when waiting
- issue_des  in  TAG_W  destination ROB tag, never 0
- full  out  1  registered; no free slot, so issue is ignored
- cdb_valid  in  1  broadcast valid
- cdb_tag  in  TAG_W  broadcast producer tag
- cdb_value  in  32  broadcast result
- flush  in  1  synchronous squash of all entries (mispredict)
- alu_op  out  4  to ALU `op`
- alu_v1, alu_v2  out  32 each  to ALU `value_1`, `value_2`
- alu_des  out  TAG_W  to ALU `des_input`; 0 = bubble

## Operation
- Each slot holds: busy, op, des, and per operand {wait, tag, value}.
- Issue:
  - When issue_valid && !full && !flush, write the lowest-index free slot.
  - If an operand has w=1, cdb_valid=1 and q==cdb_tag in the same cycle, store it as resolved with value cdb_value (same-cycle forward).
- Wakeup, every cycle cdb_valid=1: every busy slot operand with wait=1 and tag==cdb_tag clears wait and stores cdb_value. A broadcast of tag 0 is ignored.
- Ready: a slot is ready when busy && !wait1 && !wait2 at the start of the cycle. Values captured at an edge count from the next cycle.
- Select/dispatch:
  - The lowest-index ready slot is dispatched. At the edge, outputs take its op/v1/v2/des and the slot clears busy.
  - With no ready slot, outputs become op=0, v1=0, v2=0, des=0 (bubble).
- A slot freed by dispatch at edge N is reusable from edge N+1. full is computed from post-edge occupancy.
- issue_valid while full is dropped silently; the issue stage must hold the op.
- Flush wins over everything at that edge: all slots cleared, outputs set to bubble, issue and CDB ignored, full=0.
- No arithmetic is performed; values pass through bit-exact.

## Timing
- Reset (async, immediate): all busy=0, full=0, alu_op=0, alu_v1=0, alu_v2=0, alu_des=0.
- Outputs are registered on posedge. The ALU samples them at the following posedge and presents its result on the negedge after that.
- Latency, operands already known: issue at edge N, dispatch registered at edge N+1, ALU computes at edge N+2.
- Latency, waiting operand: CDB match at edge M, dispatch at edge M+1.
- Throughput: one dispatch per cycle. Issue and dispatch may happen at the same edge on different slots.
- Age order is not tracked; lowest index wins. This is decided and accepted.
- Simultaneous issue + wakeup + dispatch + CDB at one edge must all take effect without loss.

## Test plan
- Reset mid-operation with 3 busy slots -> outputs 0, des=0, full=0 immediately, without waiting for a clock.
- Issue ADD v1=5 v2=7 des=3, both ready, at edge 1 -> after edge 2: alu_op=0, alu_v1=5, alu_v2=7, alu_des=3. After edge 3, alu_des=0.
- Issue SUB des=2 with w1=1, q1=5, v2=1:
  - No dispatch while waiting.
  - cdb_valid tag=5 value=10 at edge K -> after edge K+1: op=8, v1=10, v2=1, des=2.
  - Repeat with the CDB match in the issue cycle -> dispatch one edge after issue.
- Fill 4 slots all waiting -> full=1. A 5th issue is dropped and no slot changes. Broadcast its tag -> one dispatch, full=0 the edge after.
- Two ready slots 0 and 2 -> slot 0 dispatches first, slot 2 on the next edge.
- Flush asserted in the same cycle as issue_valid and a matching CDB -> all slots empty, outputs bubble, no later dispatch of any squashed tag.

Source files
------------

// File: rtl/alu_rs.sv
// alu_rs: reservation station in front of the integer ALU.
// Holds decoded ops until both operands are known (capturing them from the
// CDB), then hands one ready op per cycle to the ALU. Tag 0 on alu_des marks
// an idle (bubble) cycle.

// ---------------------------------------------------------------------------
// One station slot: holds an op and its two operands, and watches the CDB.
// ---------------------------------------------------------------------------
module alu_rs_slot #(
    parameter int TAG_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,      // write the issued op into this slot
    input  logic             disp_en,    // this slot is being dispatched
    input  logic             flush,
    input  logic [3:0]       issue_op,
    input  logic [31:0]      issue_v1,
    input  logic [31:0]      issue_v2,
    input  logic             issue_w1,
    input  logic             issue_w2,
    input  logic [TAG_W-1:0] issue_q1,
    input  logic [TAG_W-1:0] issue_q2,
    input  logic [TAG_W-1:0] issue_des,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_value,
    output logic             busy,
    output logic             ready,
    output logic [3:0]       op,
    output logic [31:0]      v1,
    output logic [31:0]      v2,
    output logic [TAG_W-1:0] des
);

    logic             busy_q, busy_d;
    logic [3:0]       op_q, op_d;
    logic [TAG_W-1:0] des_q, des_d;
    logic             w1_q, w1_d, w2_q, w2_d;
    logic [TAG_W-1:0] q1_q, q1_d, q2_q, q2_d;
    logic [31:0]      v1_q, v1_d, v2_q, v2_d;

    // A broadcast of tag 0 carries no result and must never wake anything.
    logic cdb_live;
    assign cdb_live = cdb_valid && (cdb_tag != '0);

    // Next-state: wakeup of held operands, dispatch release, issue write, flush.
    always_comb begin
        busy_d = busy_q;
        op_d   = op_q;
        des_d  = des_q;
        w1_d   = w1_q;
        q1_d   = q1_q;
        v1_d   = v1_q;
        w2_d   = w2_q;
        q2_d   = q2_q;
        v2_d   = v2_q;

        if (busy_q && w1_q && cdb_live && (q1_q == cdb_tag)) begin
            w1_d = 1'b0;
            v1_d = cdb_value;
        end
        if (busy_q && w2_q && cdb_live && (q2_q == cdb_tag)) begin
            w2_d = 1'b0;
            v2_d = cdb_value;
        end

        if (disp_en) begin
            busy_d = 1'b0;
        end

        // Only ever asserted on a free slot, so it never collides with dispatch.
        // A matching broadcast in the issue cycle is forwarded straight in.
        if (wr_en) begin
            busy_d = 1'b1;
            op_d   = issue_op;
            des_d  = issue_des;
            q1_d   = issue_q1;
            q2_d   = issue_q2;
            if (issue_w1 && cdb_live && (issue_q1 == cdb_tag)) begin
                w1_d = 1'b0;
                v1_d = cdb_value;
            end else begin
                w1_d = issue_w1;
                v1_d = issue_v1;
            end
            if (issue_w2 && cdb_live && (issue_q2 == cdb_tag)) begin
                w2_d = 1'b0;
                v2_d = cdb_value;
            end else begin
                w2_d = issue_w2;
                v2_d = issue_v2;
            end
        end

        // Squash dominates; stale operand fields are harmless once busy is low.
        if (flush) begin
            busy_d = 1'b0;
        end
    end

    // Slot state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
            op_q   <= '0;
            des_q  <= '0;
            w1_q   <= 1'b0;
            q1_q   <= '0;
            v1_q   <= '0;
            w2_q   <= 1'b0;
            q2_q   <= '0;
            v2_q   <= '0;
        end else begin
            busy_q <= busy_d;
            op_q   <= op_d;
            des_q  <= des_d;
            w1_q   <= w1_d;
            q1_q   <= q1_d;
            v1_q   <= v1_d;
            w2_q   <= w2_d;
            q2_q   <= q2_d;
            v2_q   <= v2_d;
        end
    end

    // Readiness uses registered state only: operands captured at an edge
    // become eligible from the following cycle.
    assign busy  = busy_q;
    assign ready = busy_q && !w1_q && !w2_q;
    assign op    = op_q;
    assign v1    = v1_q;
    assign v2    = v2_q;
    assign des   = des_q;

endmodule

// ---------------------------------------------------------------------------
// Top: slot array, free-slot allocation, ready select and registered outputs.
// ---------------------------------------------------------------------------
module alu_rs #(
    parameter int ENTRIES = 4,
    parameter int TAG_W   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    input  logic [3:0]       issue_op,
    input  logic [31:0]      issue_v1,
    input  logic [31:0]      issue_v2,
    input  logic             issue_w1,
    input  logic             issue_w2,
    input  logic [TAG_W-1:0] issue_q1,
    input  logic [TAG_W-1:0] issue_q2,
    input  logic [TAG_W-1:0] issue_des,
    output logic             full,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_value,
    input  logic             flush,
    output logic [3:0]       alu_op,
    output logic [31:0]      alu_v1,
    output logic [31:0]      alu_v2,
    output logic [TAG_W-1:0] alu_des
);

    logic [ENTRIES-1:0]            slot_busy;
    logic [ENTRIES-1:0]            slot_ready;
    logic [ENTRIES-1:0][3:0]       slot_op;
    logic [ENTRIES-1:0][31:0]      slot_v1;
    logic [ENTRIES-1:0][31:0]      slot_v2;
    logic [ENTRIES-1:0][TAG_W-1:0] slot_des;

    logic [ENTRIES-1:0] wr_sel;
    logic [ENTRIES-1:0] disp_sel;

    logic             full_q, full_d;
    logic [3:0]       alu_op_q, alu_op_d;
    logic [31:0]      alu_v1_q, alu_v1_d;
    logic [31:0]      alu_v2_q, alu_v2_d;
    logic [TAG_W-1:0] alu_des_q, alu_des_d;

    genvar g;
    generate
        for (g = 0; g < ENTRIES; g++) begin : g_slot
            alu_rs_slot #(.TAG_W(TAG_W)) u_slot (
                .clk       (clk),
                .rst       (rst),
                .wr_en     (wr_sel[g]),
                .disp_en   (disp_sel[g]),
                .flush     (flush),
                .issue_op  (issue_op),
                .issue_v1  (issue_v1),
                .issue_v2  (issue_v2),
                .issue_w1  (issue_w1),
                .issue_w2  (issue_w2),
                .issue_q1  (issue_q1),
                .issue_q2  (issue_q2),
                .issue_des (issue_des),
                .cdb_valid (cdb_valid),
                .cdb_tag   (cdb_tag),
                .cdb_value (cdb_value),
                .busy      (slot_busy[g]),
                .ready     (slot_ready[g]),
                .op        (slot_op[g]),
                .v1        (slot_v1[g]),
                .v2        (slot_v2[g]),
                .des       (slot_des[g])
            );
        end
    endgenerate

    // Pick the lowest free slot for issue and the lowest ready slot for
    // dispatch (no age tracking), then form the next output and full values.
    always_comb begin
        logic found_free;
        logic found_rdy;
        wr_sel     = '0;
        disp_sel   = '0;
        found_free = 1'b0;
        found_rdy  = 1'b0;
        alu_op_d   = '0;
        alu_v1_d   = '0;
        alu_v2_d   = '0;
        alu_des_d  = '0;

        for (int i = 0; i < ENTRIES; i++) begin
            if (!slot_busy[i] && !found_free) begin
                found_free = 1'b1;
                wr_sel[i]  = issue_valid && !full_q && !flush;
            end
            if (slot_ready[i] && !found_rdy) begin
                found_rdy   = 1'b1;
                disp_sel[i] = !flush;
            end
        end

        for (int i = 0; i < ENTRIES; i++) begin
            if (disp_sel[i]) begin
                alu_op_d  = slot_op[i];
                alu_v1_d  = slot_v1[i];
                alu_v2_d  = slot_v2[i];
                alu_des_d = slot_des[i];
            end
        end

        // Occupancy after this edge: dispatched slot leaves, issued slot joins.
        full_d = !flush && (&((slot_busy & ~disp_sel) | wr_sel));
    end

    // Registered ALU-facing outputs and the full flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q    <= 1'b0;
            alu_op_q  <= '0;
            alu_v1_q  <= '0;
            alu_v2_q  <= '0;
            alu_des_q <= '0;
        end else begin
            full_q    <= full_d;
            alu_op_q  <= alu_op_d;
            alu_v1_q  <= alu_v1_d;
            alu_v2_q  <= alu_v2_d;
            alu_des_q <= alu_des_d;
        end
    end

    assign full    = full_q;
    assign alu_op  = alu_op_q;
    assign alu_v1  = alu_v1_q;
    assign alu_v2  = alu_v2_q;
    assign alu_des = alu_des_q;

endmodule

// File: tb/tb_alu_rs.sv
// Bench for alu_rs: directed stimulus with a dispatch scoreboard. Expected
// dispatches are queued when stimulus is driven and checked in order whenever
// alu_des shows a non-bubble; timing points are checked explicitly.
module tb_alu_rs;

    localparam int ENTRIES = 4;
    localparam int TAG_W   = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             issue_valid = 1'b0;
    logic [3:0]       issue_op = '0;
    logic [31:0]      issue_v1 = '0, issue_v2 = '0;
    logic             issue_w1 = 1'b0, issue_w2 = 1'b0;
    logic [TAG_W-1:0] issue_q1 = '0, issue_q2 = '0, issue_des = '0;
    logic             full;
    logic             cdb_valid = 1'b0;
    logic [TAG_W-1:0] cdb_tag = '0;
    logic [31:0]      cdb_value = '0;
    logic             flush = 1'b0;
    logic [3:0]       alu_op;
    logic [31:0]      alu_v1, alu_v2;
    logic [TAG_W-1:0] alu_des;

    alu_rs #(.ENTRIES(ENTRIES), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_op(issue_op),
        .issue_v1(issue_v1), .issue_v2(issue_v2),
        .issue_w1(issue_w1), .issue_w2(issue_w2),
        .issue_q1(issue_q1), .issue_q2(issue_q2), .issue_des(issue_des),
        .full(full),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .flush(flush),
        .alu_op(alu_op), .alu_v1(alu_v1), .alu_v2(alu_v2), .alu_des(alu_des)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]       op;
        logic [31:0]      v1;
        logic [31:0]      v2;
        logic [TAG_W-1:0] des;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_disp(input logic [3:0] op, input logic [31:0] v1, v2,
                               input logic [TAG_W-1:0] des);
        exp_t e;
        e.op = op; e.v1 = v1; e.v2 = v2; e.des = des;
        sb.push_back(e);
    endtask

    // One clock edge, then compare any dispatched op against the scoreboard.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (alu_des != '0) begin
            if (sb.size() == 0) begin
                chk("unexpected_dispatch_des", 32'(alu_des), 32'h0);
            end else begin
                e = sb.pop_front();
                chk("disp_op",  32'(alu_op),  32'(e.op));
                chk("disp_v1",  alu_v1,       e.v1);
                chk("disp_v2",  alu_v2,       e.v2);
                chk("disp_des", 32'(alu_des), 32'(e.des));
            end
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] v1, v2,
                         input logic w1, w2, input logic [TAG_W-1:0] q1, q2, des);
        issue_valid = 1'b1;
        issue_op = op; issue_v1 = v1; issue_v2 = v2;
        issue_w1 = w1; issue_w2 = w2;
        issue_q1 = q1; issue_q2 = q2; issue_des = des;
    endtask

    task automatic cdb(input logic [TAG_W-1:0] tag, input logic [31:0] val);
        cdb_valid = 1'b1; cdb_tag = tag; cdb_value = val;
    endtask

    task automatic idle();
        issue_valid = 1'b0;
        cdb_valid   = 1'b0;
        flush       = 1'b0;
    endtask

    task automatic chk_bubble(input string tag);
        chk(tag, {alu_op, alu_v1[3:0], alu_v2[3:0], 17'd0, alu_des}, 32'h0);
        chk({tag, "_v"}, alu_v1 | alu_v2, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Asynchronous reset, checked before any clock edge.
        #2 rst = 1'b1;
        #1;
        chk_bubble("reset_out");
        chk("reset_full", 32'(full), 32'h0);
        tick();
        #1 rst = 1'b0;

        // Both operands known: dispatch one edge after issue.
        issue(4'd0, 32'd5, 32'd7, 1'b0, 1'b0, 3'd0, 3'd0, 3'd3);
        expect_disp(4'd0, 32'd5, 32'd7, 3'd3);
        tick();
        idle();
        chk("add_not_yet", 32'(alu_des), 32'h0);
        tick();
        chk("add_des", 32'(alu_des), 32'd3);
        chk("add_v2", alu_v2, 32'd7);
        tick();
        chk("add_bubble", 32'(alu_des), 32'h0);

        // Waiting operand woken by the CDB.
        issue(4'd8, 32'hdead, 32'd1, 1'b1, 1'b0, 3'd5, 3'd0, 3'd2);
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("sub_wait", 32'(alu_des), 32'h0);
        end
        cdb(3'd5, 32'd10);
        expect_disp(4'd8, 32'd10, 32'd1, 3'd2);
        tick();
        idle();
        chk("sub_wake_not_yet", 32'(alu_des), 32'h0);
        tick();
        chk("sub_des", 32'(alu_des), 32'd2);

        // CDB match in the issue cycle is forwarded.
        issue(4'd8, 32'hbeef, 32'd9, 1'b1, 1'b0, 3'd6, 3'd0, 3'd4);
        cdb(3'd6, 32'h55);
        expect_disp(4'd8, 32'h55, 32'd9, 3'd4);
        tick();
        idle();
        tick();
        chk("fwd_des", 32'(alu_des), 32'd4);
        tick();

        // Fill all slots with waiting ops; slot i waits on tag i+1.
        for (int i = 0; i < ENTRIES; i++) begin
            issue(4'(i + 1), 32'h0, 32'(i), 1'b1, 1'b0, 3'(i + 1), 3'd0, 3'(i + 4));
            tick();
        end
        idle();
        chk("fill_full", 32'(full), 32'h1);
        // A ready op offered while full must vanish.
        issue(4'd13, 32'h1, 32'h2, 1'b0, 1'b0, 3'd0, 3'd0, 3'd1);
        tick();
        idle();
        chk("drop_full", 32'(full), 32'h1);
        tick();
        chk("drop_no_disp", 32'(alu_des), 32'h0);
        cdb(3'd3, 32'h333);
        expect_disp(4'd3, 32'h333, 32'd2, 3'd6);
        tick();
        idle();
        chk("wake_still_full", 32'(full), 32'h1);
        tick();
        chk("wake_des", 32'(alu_des), 32'd6);
        chk("wake_not_full", 32'(full), 32'h0);
        flush = 1'b1;
        tick();
        idle();
        chk("flush1_full", 32'(full), 32'h0);

        // Slots 0 and 2 woken together: lowest index first.
        issue(4'd1, 32'h0, 32'h10, 1'b1, 1'b0, 3'd1, 3'd0, 3'd1);
        tick();
        issue(4'd2, 32'h0, 32'h20, 1'b1, 1'b0, 3'd2, 3'd0, 3'd2);
        tick();
        issue(4'd3, 32'h0, 32'h30, 1'b1, 1'b0, 3'd1, 3'd0, 3'd3);
        tick();
        idle();
        cdb(3'd1, 32'haa);
        expect_disp(4'd1, 32'haa, 32'h10, 3'd1);
        expect_disp(4'd3, 32'haa, 32'h30, 3'd3);
        tick();
        idle();
        tick();
        chk("order_first", 32'(alu_des), 32'd1);
        tick();
        chk("order_second", 32'(alu_des), 32'd3);
        tick();
        chk("order_bubble", 32'(alu_des), 32'h0);

        // Flush beats a same-cycle issue and a matching CDB for slot 1.
        issue(4'd4, 32'h1, 32'h2, 1'b0, 1'b0, 3'd0, 3'd0, 3'd5);
        cdb(3'd2, 32'hbb);
        flush = 1'b1;
        tick();
        idle();
        chk_bubble("flush_out");
        chk("flush_full", 32'(full), 32'h0);
        cdb(3'd2, 32'hbb);
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("flush_no_disp", 32'(alu_des), 32'h0);
        end

        // Reset in the middle of activity: three waiting slots, one dispatch shown.
        issue(4'd1, 32'h0, 32'h0, 1'b1, 1'b0, 3'd1, 3'd0, 3'd1);
        tick();
        issue(4'd2, 32'h0, 32'h0, 1'b1, 1'b0, 3'd2, 3'd0, 3'd2);
        tick();
        issue(4'd3, 32'h0, 32'h0, 1'b1, 1'b0, 3'd3, 3'd0, 3'd3);
        tick();
        issue(4'd5, 32'h11, 32'h22, 1'b0, 1'b0, 3'd0, 3'd0, 3'd7);
        expect_disp(4'd5, 32'h11, 32'h22, 3'd7);
        tick();
        idle();
        chk("pre_rst_full", 32'(full), 32'h1);
        tick();
        chk("pre_rst_des", 32'(alu_des), 32'd7);
        #1 rst = 1'b1;
        #1;
        chk_bubble("midrst_out");
        chk("midrst_full", 32'(full), 32'h0);
        tick();
        #1 rst = 1'b0;
        for (int t = 1; t <= 3; t++) begin
            cdb(3'(t), 32'(t));
            tick();
        end
        idle();
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("postrst_no_disp", 32'(alu_des), 32'h0);
        end

        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
